conv_loop_iter: RTL and testbench



---
 rtl/conv_loop_iter.sv | 129 ++++++++++++
 tb/tb_conv_loop_iter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_iter.sv
// Convolution loop index generator: issues one (m, r, c, n, i, j) tuple per clock
// for the conv address controller, with stall, per-pixel tap_last and a done pulse.
module conv_loop_iter #(
    parameter int K           = 5,
    parameter int OUT_SIZE    = 28,
    parameter int OUT_CHANNEL = 6,
    parameter int IN_CHANNEL  = 1,
    parameter int N_STEP      = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stall,
    output logic [7:0] m,
    output logic [7:0] r,
    output logic [7:0] c,
    output logic [7:0] n,
    output logic [3:0] i,
    output logic [3:0] j,
    output logic       valid,
    output logic       tap_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam logic [3:0] K_LAST  = 4'(K - 1);
    localparam logic [7:0] OS_LAST = 8'(OUT_SIZE - 1);
    localparam logic [7:0] OC_LAST = 8'(OUT_CHANNEL - 1);
    localparam logic [7:0] N_LAST  = 8'(N_STEP * (IN_CHANNEL - 1));
    localparam logic [7:0] N_INC   = 8'(N_STEP);

    state_t state, state_next;

    logic j_wrap, i_wrap, n_wrap, c_wrap, r_wrap, m_wrap;
    logic last_tuple;
    logic advance;

    always_comb begin
        j_wrap     = (j == K_LAST);
        i_wrap     = (i == K_LAST);
        n_wrap     = (n == N_LAST);
        c_wrap     = (c == OS_LAST);
        r_wrap     = (r == OS_LAST);
        m_wrap     = (m == OC_LAST);
        last_tuple = j_wrap & i_wrap & n_wrap & c_wrap & r_wrap & m_wrap;
        advance    = (state == RUN) & ~stall;
    end

    // State register; busy and done are registered from the next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == FIN);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (advance && last_tuple) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        valid    = (state == RUN) & ~stall;
        tap_last = valid & i_wrap & j_wrap & n_wrap;
    end

    // Odometer-style cascade, j innermost; the final tuple leaves all indices at max.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m <= '0;
            r <= '0;
            c <= '0;
            n <= '0;
            i <= '0;
            j <= '0;
        end else if (state == FIN) begin
            m <= '0;
            r <= '0;
            c <= '0;
            n <= '0;
            i <= '0;
            j <= '0;
        end else if (advance && !last_tuple) begin
            if (j_wrap) begin
                j <= '0;
                if (i_wrap) begin
                    i <= '0;
                    if (n_wrap) begin
                        n <= '0;
                        if (c_wrap) begin
                            c <= '0;
                            if (r_wrap) begin
                                r <= '0;
                                m <= m + 8'd1;
                            end else begin
                                r <= r + 8'd1;
                            end
                        end else begin
                            c <= c + 8'd1;
                        end
                    end else begin
                        n <= n + N_INC;
                    end
                end else begin
                    i <= i + 4'd1;
                end
            end else begin
                j <= j + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_loop_iter.sv
// Randomized self-checking bench for conv_loop_iter: a default-geometry instance and a
// small-geometry instance, both checked every cycle against an arithmetic tuple model.
module tb_conv_loop_iter;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_FIN  = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_a, start_a, stall_a;
    logic [7:0] a_m, a_r, a_c, a_n;
    logic [3:0] a_i, a_j;
    logic       a_valid, a_tap, a_busy, a_done;

    logic       rst_b, start_b, stall_b;
    logic [7:0] b_m, b_r, b_c, b_n;
    logic [3:0] b_i, b_j;
    logic       b_valid, b_tap, b_busy, b_done;

    conv_loop_iter dut_a (
        .clock(clock), .reset_n(rst_a), .start(start_a), .stall(stall_a),
        .m(a_m), .r(a_r), .c(a_c), .n(a_n), .i(a_i), .j(a_j),
        .valid(a_valid), .tap_last(a_tap), .busy(a_busy), .done(a_done)
    );

    conv_loop_iter #(
        .K(2), .OUT_SIZE(2), .OUT_CHANNEL(2), .IN_CHANNEL(2), .N_STEP(4)
    ) dut_b (
        .clock(clock), .reset_n(rst_b), .start(start_b), .stall(stall_b),
        .m(b_m), .r(b_r), .c(b_c), .n(b_n), .i(b_i), .j(b_j),
        .valid(b_valid), .tap_last(b_tap), .busy(b_busy), .done(b_done)
    );

    int sel;
    int g_k, g_os, g_oc, g_ic, g_step, total;
    int ph, tcount;
    int n_checks, n_fail;
    int n_valid, n_tap, n_done, cyc, done_at;

    logic [39:0] obs_idx;
    logic [3:0]  obs_flags;

    always_comb begin
        if (sel == 0) begin
            obs_idx   = {a_m, a_r, a_c, a_n, a_i, a_j};
            obs_flags = {a_valid, a_tap, a_busy, a_done};
        end else begin
            obs_idx   = {b_m, b_r, b_c, b_n, b_i, b_j};
            obs_flags = {b_valid, b_tap, b_busy, b_done};
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic select(input int s);
        sel = s;
        if (s == 0) begin
            g_k = 5; g_os = 28; g_oc = 6; g_ic = 1; g_step = 4;
        end else begin
            g_k = 2; g_os = 2; g_oc = 2; g_ic = 2; g_step = 4;
        end
        total  = g_oc * g_os * g_os * g_ic * g_k * g_k;
        ph     = P_IDLE;
        tcount = 0;
    endtask

    // Decompose the linear tuple number into loop indices, j fastest.
    function automatic logic [39:0] tuple_of(input int t);
        int q, jj, ii, nn, cc, rr, mm;
        q  = t;
        jj = q % g_k;  q = q / g_k;
        ii = q % g_k;  q = q / g_k;
        nn = g_step * (q % g_ic); q = q / g_ic;
        cc = q % g_os; q = q / g_os;
        rr = q % g_os; q = q / g_os;
        mm = q;
        return {8'(mm), 8'(rr), 8'(cc), 8'(nn), 4'(ii), 4'(jj)};
    endfunction

    task automatic step(input logic st, input logic sl);
        logic ev, et;
        @(posedge clock);
        #1;
        start_a = (sel == 0) ? st : 1'b0;
        stall_a = (sel == 0) ? sl : 1'b0;
        start_b = (sel == 1) ? st : 1'b0;
        stall_b = (sel == 1) ? sl : 1'b0;
        @(negedge clock);
        cyc++;
        ev = (ph == P_RUN) && !sl;
        et = ev && ((tcount % (g_k * g_k * g_ic)) == (g_k * g_k * g_ic - 1));
        chk("idx", obs_idx, tuple_of(tcount));
        chk("flags", obs_flags, {ev, et, ph == P_RUN, ph == P_FIN});
        if (obs_flags[3]) n_valid++;
        if (obs_flags[2]) n_tap++;
        if (obs_flags[0]) begin
            n_done++;
            done_at = cyc;
        end
        case (ph)
            P_IDLE: if (st) begin ph = P_RUN; tcount = 0; end
            P_RUN:  if (!sl) begin
                        if (tcount == total - 1) ph = P_FIN;
                        else tcount++;
                    end
            default: begin ph = P_IDLE; tcount = 0; end
        endcase
    endtask

    task automatic run_pass(input int stall_pct, input bit lat_check);
        int k, start_cyc;
        n_valid = 0; n_tap = 0; n_done = 0; done_at = -1;
        step(1'b1, 1'b0);
        start_cyc = cyc;
        k = 0;
        while (ph != P_IDLE && k < 3 * total + 100) begin
            // A start during FIN exercises the ignored-start case on the way back to IDLE.
            step((ph == P_FIN) ? 1'b1 : ($urandom_range(0, 29) == 0),
                 (ph == P_RUN) && ($urandom_range(0, 99) < stall_pct));
            k++;
        end
        if (ph != P_IDLE) chk("pass_timeout", 1, 0);
        step(1'b0, 1'b0);
        chk("n_valid", n_valid, total);
        chk("n_tap", n_tap, g_oc * g_os * g_os);
        chk("n_done", n_done, 1);
        if (lat_check) chk("latency", done_at - start_cyc, total + 1);
    endtask

    initial begin
        int k;
        n_checks = 0; n_fail = 0; cyc = 0;
        n_valid = 0; n_tap = 0; n_done = 0; done_at = -1;
        start_a = 0; stall_a = 0; start_b = 0; stall_b = 0;
        rst_a = 0; rst_b = 0;
        select(0);

        for (int q = 0; q < 3; q++) step(1'b0, 1'b0);
        @(posedge clock);
        #1;
        rst_a = 1; rst_b = 1;
        for (int q = 0; q < 20; q++) step(1'b0, 1'($urandom_range(0, 1)));

        // Default geometry: start, run to (i=2,j=3), hold a 3-cycle stall, then random traffic.
        step(1'b1, 1'b0);
        k = 0;
        while (tcount < 13 && k < 100) begin step(1'b0, 1'b0); k++; end
        chk("reach_13", tcount, 13);
        for (int q = 0; q < 3; q++) step(1'b0, 1'b1);
        k = 0;
        while (tcount < 1000 && k < 4000) begin
            step(($urandom_range(0, 29) == 0), ($urandom_range(0, 99) < 20));
            k++;
        end
        chk("reach_1000", tcount, 1000);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst_a = 0;
        #1;
        chk("rst_idx", obs_idx, 40'd0);
        chk("rst_flags", obs_flags, 4'd0);
        ph = P_IDLE;
        tcount = 0;
        n_done = 0;
        for (int q = 0; q < 3; q++) step(1'b0, 1'b0);
        @(posedge clock);
        #1;
        rst_a = 1;
        for (int q = 0; q < 3; q++) step(1'b0, 1'b0);
        chk("no_done_after_rst", n_done, 0);

        step(1'b1, 1'b0);
        for (int q = 0; q < 40; q++) step(1'b0, 1'($urandom_range(0, 3) == 0));

        select(1);
        run_pass(0, 1'b1);
        run_pass(30, 1'b0);
        run_pass(60, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
